// File: rtl/ast_packet_gen.sv
// Avalon-ST packet source: takes one {len, channel, seed} command at a time and
// streams the packet MSB-byte-first with sop/eop/empty framing and an incrementing byte pattern.
module ast_packet_gen #(
  parameter int AST_DWIDTH    = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int LEN_WIDTH     = 11,
  localparam int EMPTY_WIDTH  = ((AST_DWIDTH / 8) > 1) ? $clog2(AST_DWIDTH / 8) : 1
) (
  input  logic                     clk_i,
  input  logic                     srst_n_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [LEN_WIDTH-1:0]     cmd_len_i,
  input  logic [CHANNEL_WIDTH-1:0] cmd_channel_i,
  input  logic [7:0]               cmd_seed_i,
  input  logic                     src_ready_i,
  output logic [AST_DWIDTH-1:0]    src_data_o,
  output logic                     src_valid_o,
  output logic                     src_startofpacket_o,
  output logic                     src_endofpacket_o,
  output logic [EMPTY_WIDTH-1:0]   src_empty_o,
  output logic [CHANNEL_WIDTH-1:0] src_channel_o,
  output logic                     err_o,
  output logic [15:0]              pkt_cnt_o
);

  localparam int BYTES   = AST_DWIDTH / 8;
  localparam int OFF_W   = LEN_WIDTH + 1;
  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;

  typedef enum logic [0:0] {IDLE_S, SEND_S} state_t;

  state_t                   state_q, state_nxt;
  logic [LEN_WIDTH-1:0]     len_q, len_nxt;
  logic [7:0]               seed_q, seed_nxt;
  logic [OFF_W-1:0]         off_q, off_nxt, off_adv;
  logic [AST_DWIDTH-1:0]    data_p1, data_nxt;
  logic                     vld_p1, vld_nxt;
  logic                     sop_p1, sop_nxt;
  logic                     eop_p1, eop_nxt;
  logic [EMPTY_WIDTH-1:0]   empty_p1, empty_nxt;
  logic [CHANNEL_WIDTH-1:0] chan_p1, chan_nxt;
  logic [15:0]              cnt_q, cnt_nxt;
  logic                     err_q, err_nxt;
  logic                     last_w;
  logic                     len_ok;

  // Word starting at byte offset off; bytes at or past len are zero.
  function automatic logic [AST_DWIDTH-1:0] build_word(input logic [7:0] seed,
                                                       input logic [OFF_W-1:0] off,
                                                       input logic [LEN_WIDTH-1:0] len);
    logic [OFF_W-1:0] k;
    build_word = '0;
    for (int j = 0; j < BYTES; j++) begin
      k = off + OFF_W'(j);
      if (k < {1'b0, len})
        build_word[AST_DWIDTH-1-8*j -: 8] = seed + k[7:0];
    end
  endfunction

  function automatic logic is_last(input logic [OFF_W-1:0] off, input logic [LEN_WIDTH-1:0] len);
    return (off + OFF_W'(BYTES)) >= {1'b0, len};
  endfunction

  // Only meaningful on the eop word, where the difference is below BYTES.
  function automatic logic [EMPTY_WIDTH-1:0] empty_of(input logic [OFF_W-1:0] off,
                                                      input logic [LEN_WIDTH-1:0] len);
    logic [OFF_W-1:0] span;
    span = off + OFF_W'(BYTES) - {1'b0, len};
    return span[EMPTY_WIDTH-1:0];
  endfunction

  assign len_ok = (int'(cmd_len_i) >= MIN_LEN) && (int'(cmd_len_i) <= MAX_LEN);

  always_comb begin
    state_nxt   = state_q;
    len_nxt     = len_q;
    seed_nxt    = seed_q;
    off_nxt     = off_q;
    off_adv     = off_q + OFF_W'(BYTES);
    data_nxt    = data_p1;
    vld_nxt     = vld_p1;
    sop_nxt     = sop_p1;
    eop_nxt     = eop_p1;
    empty_nxt   = empty_p1;
    chan_nxt    = chan_p1;
    cnt_nxt     = cnt_q;
    err_nxt     = 1'b0;
    last_w      = 1'b0;
    cmd_ready_o = (state_q == IDLE_S);
    case (state_q)
      IDLE_S: begin
        if (cmd_valid_i) begin
          if (len_ok) begin
            last_w    = is_last('0, cmd_len_i);
            len_nxt   = cmd_len_i;
            seed_nxt  = cmd_seed_i;
            off_nxt   = '0;
            data_nxt  = build_word(cmd_seed_i, '0, cmd_len_i);
            vld_nxt   = 1'b1;
            sop_nxt   = 1'b1;
            eop_nxt   = last_w;
            empty_nxt = last_w ? empty_of('0, cmd_len_i) : '0;
            chan_nxt  = cmd_channel_i;
            state_nxt = SEND_S;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      SEND_S: begin
        // Outputs only move on a transfer; otherwise they hold.
        if (vld_p1 && src_ready_i) begin
          if (eop_p1) begin
            vld_nxt   = 1'b0;
            sop_nxt   = 1'b0;
            eop_nxt   = 1'b0;
            empty_nxt = '0;
            data_nxt  = '0;
            cnt_nxt   = cnt_q + 16'd1;
            state_nxt = IDLE_S;
          end else begin
            last_w    = is_last(off_adv, len_q);
            off_nxt   = off_adv;
            data_nxt  = build_word(seed_q, off_adv, len_q);
            sop_nxt   = 1'b0;
            eop_nxt   = last_w;
            empty_nxt = last_w ? empty_of(off_adv, len_q) : '0;
          end
        end
      end
      default: state_nxt = IDLE_S;
    endcase
  end

  // Registered output stage
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q  <= IDLE_S;
      data_p1  <= '0;
      vld_p1   <= 1'b0;
      sop_p1   <= 1'b0;
      eop_p1   <= 1'b0;
      empty_p1 <= '0;
      chan_p1  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      data_p1  <= data_nxt;
      vld_p1   <= vld_nxt;
      sop_p1   <= sop_nxt;
      eop_p1   <= eop_nxt;
      empty_p1 <= empty_nxt;
      chan_p1  <= chan_nxt;
      cnt_q    <= cnt_nxt;
      err_q    <= err_nxt;
    end
  end

  // Packet context is reloaded on every accept, so it carries no reset.
  always_ff @(posedge clk_i) begin
    len_q  <= len_nxt;
    seed_q <= seed_nxt;
    off_q  <= off_nxt;
  end

  assign src_data_o          = data_p1;
  assign src_valid_o         = vld_p1;
  assign src_startofpacket_o = sop_p1;
  assign src_endofpacket_o   = eop_p1;
  assign src_empty_o         = empty_p1;
  assign src_channel_o       = chan_p1;
  assign err_o               = err_q;
  assign pkt_cnt_o           = cnt_q;

endmodule

// File: tb/tb_ast_packet_gen.sv
// Bench for ast_packet_gen: table of packet commands plus hand-written reset and
// back-to-back sequences; a negedge monitor pops a scoreboard of expected words.
module tb_ast_packet_gen;

  logic        clk = 1'b0;
  logic        srst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [10:0] cmd_len = '0;
  logic        cmd_channel = 1'b0;
  logic [7:0]  cmd_seed = '0;
  logic        src_ready = 1'b1;
  logic [63:0] src_data;
  logic        src_valid, src_sop, src_eop;
  logic [2:0]  src_empty;
  logic        src_channel;
  logic        err;
  logic [15:0] pkt_cnt;

  ast_packet_gen dut (
    .clk_i               (clk),
    .srst_n_i            (srst_n),
    .cmd_valid_i         (cmd_valid),
    .cmd_ready_o         (cmd_ready),
    .cmd_len_i           (cmd_len),
    .cmd_channel_i       (cmd_channel),
    .cmd_seed_i          (cmd_seed),
    .src_ready_i         (src_ready),
    .src_data_o          (src_data),
    .src_valid_o         (src_valid),
    .src_startofpacket_o (src_sop),
    .src_endofpacket_o   (src_eop),
    .src_empty_o         (src_empty),
    .src_channel_o       (src_channel),
    .err_o               (err),
    .pkt_cnt_o           (pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic        ch;
  } exp_t;

  typedef struct {
    logic [10:0] len;
    logic [7:0]  seed;
    logic        ch;
    bit          toggle;
    bit          illegal;
    int          words;
    logic [2:0]  empty;
    logic [63:0] first;
    logic [63:0] last;
  } vec_t;

  exp_t        sbq[$];
  vec_t        vt[6];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          exp_cnt = 0;
  bit          ready_mode = 1'b0;

  bit          hold_pend = 1'b0;
  logic [63:0] hold_data;
  logic [63:0] hold_frame;
  logic [63:0] cur_frame;
  exp_t        mon_e;
  int          mon_words = 0;
  int          mon_prev_cyc = 0;
  int          mon_eop_cyc = 0;
  int          mon_gap = 0;
  logic [63:0] mon_first = '0;
  logic [63:0] mon_last = '0;
  logic [2:0]  mon_empty = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode) src_ready = ~src_ready;
    else            src_ready = 1'b1;
  end

  // Monitor: hold check under backpressure, scoreboard compare on each transfer
  always @(negedge clk) begin
    cur_frame = 64'({src_valid, src_sop, src_eop, src_empty, src_channel});
    if (hold_pend && srst_n) begin
      chk("hold_data", src_data, hold_data);
      chk("hold_frame", cur_frame, hold_frame);
    end
    hold_pend  = src_valid && !src_ready;
    hold_data  = src_data;
    hold_frame = cur_frame;
    if (src_valid && src_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_word", 64'd1, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("word_data", src_data, mon_e.data);
        chk("word_frame", 64'({src_sop, src_eop, src_empty, src_channel}),
            64'({mon_e.sop, mon_e.eop, mon_e.empty, mon_e.ch}));
      end
      if (src_sop) begin
        mon_words = 0;
        mon_first = src_data;
        mon_gap   = cyc - mon_eop_cyc;
      end else if (!ready_mode) begin
        chk("consecutive", 64'(cyc), 64'(mon_prev_cyc + 1));
      end
      mon_words++;
      mon_prev_cyc = cyc;
      if (src_eop) begin
        mon_last    = src_data;
        mon_empty   = src_empty;
        mon_eop_cyc = cyc;
      end
    end
  end

  task automatic push_pkt(input logic [10:0] len, input logic [7:0] seed, input logic ch);
    int   w;
    exp_t e;
    w = (int'(len) + 7) / 8;
    for (int i = 0; i < w; i++) begin
      e.data = '0;
      for (int j = 0; j < 8; j++) begin
        int k = i * 8 + j;
        if (k < int'(len)) e.data[63-8*j -: 8] = seed + 8'(k);
      end
      e.sop   = (i == 0);
      e.eop   = (i == w - 1);
      e.empty = e.eop ? 3'(w * 8 - int'(len)) : 3'd0;
      e.ch    = ch;
      sbq.push_back(e);
    end
  endtask

  task automatic send_cmd(input logic [10:0] len, input logic ch, input logic [7:0] seed);
    bit acc;
    int n;
    n = 0;
    cmd_len     = len;
    cmd_channel = ch;
    cmd_seed    = seed;
    cmd_valid   = 1'b1;
    do begin
      acc = cmd_ready;
      step();
      n++;
    end while (!acc && n < 4000);
    cmd_valid = 1'b0;
    chk("cmd_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || src_valid) && n < 4000) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(n >= 4000), 64'd0);
  endtask

  task automatic pulse_reset();
    srst_n = 1'b0;
    step();
    srst_n = 1'b1;
    sbq.delete();
    exp_cnt = 0;
  endtask

  initial begin
    vt[0] = '{len: 11'd60,   seed: 8'h00, ch: 1'b0, toggle: 1'b0, illegal: 1'b0, words: 8,
              empty: 3'd4, first: 64'h0001020304050607, last: 64'h38393A3B00000000};
    vt[1] = '{len: 11'd1514, seed: 8'h00, ch: 1'b0, toggle: 1'b0, illegal: 1'b0, words: 190,
              empty: 3'd6, first: 64'h0001020304050607, last: 64'hE8E9000000000000};
    vt[2] = '{len: 11'd64,   seed: 8'hFC, ch: 1'b0, toggle: 1'b1, illegal: 1'b0, words: 8,
              empty: 3'd0, first: 64'hFCFDFEFF00010203, last: 64'h3435363738393A3B};
    vt[3] = '{len: 11'd59,   seed: 8'h11, ch: 1'b0, toggle: 1'b0, illegal: 1'b1, words: 0,
              empty: 3'd0, first: 64'h0, last: 64'h0};
    vt[4] = '{len: 11'd1515, seed: 8'h22, ch: 1'b1, toggle: 1'b0, illegal: 1'b1, words: 0,
              empty: 3'd0, first: 64'h0, last: 64'h0};
    vt[5] = '{len: 11'd61,   seed: 8'h10, ch: 1'b1, toggle: 1'b1, illegal: 1'b0, words: 8,
              empty: 3'd3, first: 64'h1011121314151617, last: 64'h48494A4B4C000000};

    srst_n = 1'b0;
    step();
    step();
    srst_n = 1'b1;
    chk("rst_valid", 64'(src_valid), 64'd0);
    chk("rst_data", src_data, 64'd0);
    chk("rst_frame", 64'({src_sop, src_eop, src_empty, src_channel}), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      ready_mode = vt[i].toggle;
      if (!vt[i].illegal) begin
        push_pkt(vt[i].len, vt[i].seed, vt[i].ch);
        send_cmd(vt[i].len, vt[i].ch, vt[i].seed);
        wait_drain();
        exp_cnt++;
        chk("tbl_words", 64'(mon_words), 64'(vt[i].words));
        chk("tbl_first", mon_first, vt[i].first);
        chk("tbl_last", mon_last, vt[i].last);
        chk("tbl_empty", 64'(mon_empty), 64'(vt[i].empty));
        chk("tbl_cnt", 64'(pkt_cnt), 64'(exp_cnt));
      end else begin
        send_cmd(vt[i].len, vt[i].ch, vt[i].seed);
        chk("err_pulse", 64'(err), 64'd1);
        chk("err_no_valid", 64'(src_valid), 64'd0);
        step();
        chk("err_one_cycle", 64'(err), 64'd0);
        chk("err_no_valid2", 64'(src_valid), 64'd0);
        chk("err_cnt", 64'(pkt_cnt), 64'(exp_cnt));
      end
      ready_mode = 1'b0;
      step();
    end

    // Reset after the third transfer of a 128-byte packet
    push_pkt(11'd128, 8'h20, 1'b0);
    send_cmd(11'd128, 1'b0, 8'h20);
    step();
    step();
    step();
    pulse_reset();
    chk("mid_rst_valid", 64'(src_valid), 64'd0);
    chk("mid_rst_cnt", 64'(pkt_cnt), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    step();
    chk("mid_rst_still_idle", 64'(src_valid), 64'd0);
    push_pkt(11'd60, 8'h40, 1'b0);
    send_cmd(11'd60, 1'b0, 8'h40);
    wait_drain();
    exp_cnt++;
    chk("post_rst_first", mon_first, 64'h4041424344454647);
    chk("post_rst_words", 64'(mon_words), 64'd8);
    chk("post_rst_cnt", 64'(pkt_cnt), 64'(exp_cnt));

    // Back-to-back commands, second held while the first packet is in flight
    pulse_reset();
    step();
    push_pkt(11'd60, 8'h00, 1'b0);
    push_pkt(11'd61, 8'h00, 1'b1);
    send_cmd(11'd60, 1'b0, 8'h00);
    send_cmd(11'd61, 1'b1, 8'h00);
    wait_drain();
    chk("b2b_gap", 64'(mon_gap), 64'd2);
    chk("b2b_words", 64'(mon_words), 64'd8);
    chk("b2b_empty", 64'(mon_empty), 64'd3);
    chk("b2b_last", mon_last, 64'h38393A3B3C000000);
    chk("b2b_cnt", 64'(pkt_cnt), 64'd2);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ast_packet_gen.md
Name: ast_packet_gen

Overview:
- Avalon-ST packet transmitter: accepts one packet command at a time and emits the whole packet on an Avalon-ST source.
- Each command carries a byte length, a channel and a seed. The block produces sop/eop/empty/channel framing and a deterministic byte pattern.
- Honours backpressure on src_ready_i.
- Acts as the traffic source feeding the packet resolver path; the bench uses it as a stimulus generator.

Parameters:
- AST_DWIDTH, 64, data bus width in bits; multiple of 8. BYTES = AST_DWIDTH/8.
- CHANNEL_WIDTH, 1, channel field width.
- LEN_WIDTH, 11, width of the packet byte-length field.
- EMPTY_WIDTH (localparam), $clog2(AST_DWIDTH/8), width of the empty field.

Ports:
- clk_i  in  1  clock.
- srst_n_i  in  1  synchronous reset, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready; high only in IDLE_S.
- cmd_len_i  in  LEN_WIDTH  packet length in bytes.
- cmd_channel_i  in  CHANNEL_WIDTH  channel driven for the whole packet.
- cmd_seed_i  in  8  value of payload byte 0.
- src_ready_i  in  1  Avalon-ST ready, readyLatency 0.
- src_data_o  out  AST_DWIDTH  data; first byte in the most-significant byte.
- src_valid_o  out  1  data valid.
- src_startofpacket_o  out  1  sop.
- src_endofpacket_o  out  1  eop.
- src_empty_o  out  EMPTY_WIDTH  unused bytes in the eop word; 0 on every other word.
- src_channel_o  out  CHANNEL_WIDTH  channel.
- err_o  out  1  one-cycle pulse when a command with an illegal length is dropped.
- pkt_cnt_o  out  16  count of completed packets; wraps at 65535 -> 0.

Behaviour:
- Reset, sampled at the clock edge while srst_n_i=0:
  - all src_* outputs, err_o and pkt_cnt_o go to 0; cmd_ready_o=1; state=IDLE_S.
  - Reset in mid-packet truncates the packet immediately: no eop is sent and pkt_cnt_o is not incremented.
- All src_* outputs are registered.
- Word transfer occurs on a clock edge with src_valid_o=1 and src_ready_i=1.
- While src_valid_o=1 and src_ready_i=0, all src_* outputs hold their values.
- Legal length: 60 <= cmd_len_i <= 1514.
- Command accept: cmd_valid_i=1 and cmd_ready_o=1 at the edge.
  - Illegal length: the command is consumed and err_o=1 in the next cycle; state stays IDLE_S; no src_valid_o.
- Latched at accept: len, channel, seed.
  - Word count W = ceil(len/BYTES).
  - Empty value E = W*BYTES - len.
- Payload byte k (0-based across the packet) = (seed + k) mod 256.
  - Word i carries bytes i*BYTES .. i*BYTES+BYTES-1, byte i*BYTES in bits [AST_DWIDTH-1 -: 8].
  - Bytes at or beyond len in the eop word are driven 0.
- State IDLE_S: cmd_ready_o=1, src_valid_o=0. A legal command moves the FSM to SEND_S; word 0 is presented (valid, sop) on the cycle after accept.
- State SEND_S: cmd_ready_o=0.
  - Word index counter advances on each transfer.
  - sop=1 only on word 0; eop=1 and empty=E only on word W-1; channel is constant.
  - On the edge transferring word W-1: pkt_cnt_o increments, src_valid_o drops to 0, and the FSM returns to IDLE_S.
- Back-to-back commands: minimum one cycle with src_valid_o=0 between packets.
  - The last word transfers at edge N; a command is accepted at N+1; the next sop is valid after N+1.
- src_valid_o never depends combinationally on src_ready_i.
- cmd_* inputs are ignored outside IDLE_S.

Test Plan:
- len=60, seed=0x00, ready tied 1 -> 8 words on 8 consecutive cycles:
  - word0=0x0001020304050607 with sop=1.
  - word7=0x38393A3B00000000 with eop=1, empty=4.
  - pkt_cnt_o=1.
- len=1514, seed=0x00 -> 190 words; word189=0xE8E9000000000000 with eop=1, empty=6; sop only on word0.
- len=64, seed=0xFC, ready pattern 1,0,1,0,... -> 8 transfers, empty=0:
  - word0=0xFCFDFEFF00010203.
  - src_* outputs stable across every ready=0 cycle.
- cmd len=59, then len=1515 -> err_o pulses once per command; src_valid_o stays 0; pkt_cnt_o unchanged.
- len=128, srst_n_i=0 for 1 cycle after the 3rd transfer:
  - next cycle src_valid_o=0, pkt_cnt_o=0, cmd_ready_o=1.
  - A new len=60 command afterwards produces a clean packet starting with sop.
- Two queued legal commands (len=60, then len=61 with channel=1) -> exactly one idle cycle between eop and sop:
  - second packet: 8 words, empty=3, src_channel_o=1 on all words.
  - pkt_cnt_o=2.
